ra_stack: RTL and testbench

- Hardware return-address stack for the accumulator processor; this is the consumer side of the call/return path.
- Call instructions push the return address.
- Return instructions pop it, and the top entry drives the PC-select mux as the jump target.
- Allows nested calls up to DEPTH levels without software saving the single return-address register to memory.

---
 rtl/ra_stack_pkg.sv | 7 +
 rtl/ra_stack_mem.sv | 23 ++
 rtl/ra_stack.sv | 117 +++++++++++
 tb/tb_ra_stack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ra_stack_pkg.sv
// Shared constants and the return-address word type for the return-address stack.
package ra_stack_pkg;
    localparam int RA_WIDTH         = 16;
    localparam int RA_DEPTH_DEFAULT = 8;

    typedef logic [RA_WIDTH-1:0] ra_word_t;
endpackage

// File: rtl/ra_stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module ra_stack_mem import ra_stack_pkg::*; #(
    parameter int WIDTH = RA_WIDTH,
    parameter int DEPTH = RA_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ra_stack.sv
// Hardware return-address stack: push on call, pop on return, push+pop replaces the top.
// Define RAS_OVERFLOW_WRAP_EN to make a push while full overwrite the oldest entry instead of dropping.
module ra_stack import ra_stack_pkg::*; #(
    parameter int   WIDTH = $bits(ra_word_t),
    parameter int   DEPTH = RA_DEPTH_DEFAULT,
    localparam int  PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] ra_in,
    output logic [WIDTH-1:0] ra_out,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow_err,
    output logic             underflow_err,
    input  logic             err_clr
);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_top;
    logic [PTR_W:0]   r_count;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic [PTR_W-1:0] w_top_m1;
    logic [PTR_W-1:0] w_top_nxt;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_we;
    logic [PTR_W-1:0] w_waddr;
    logic [WIDTH-1:0] w_rdata;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_FULL);
    assign w_top_m1 = r_top - PTR_ONE;

    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_top;
        w_top_nxt   = r_top;
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        if (push && !pop) begin
            if (!w_full) begin
                w_we        = 1'b1;
                w_top_nxt   = r_top + PTR_ONE;
                w_count_nxt = r_count + CNT_ONE;
            end else begin
                w_ovf_set   = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
                // Top has wrapped onto the oldest slot, so writing there evicts it.
                w_we        = 1'b1;
                w_top_nxt   = r_top + PTR_ONE;
`endif
            end
        end else if (pop && !push) begin
            if (!w_empty) begin
                w_top_nxt   = w_top_m1;
                w_count_nxt = r_count - CNT_ONE;
            end else begin
                w_unf_set   = 1'b1;
            end
        end else if (push && pop) begin
            w_we = 1'b1;
            if (w_empty) begin
                w_top_nxt   = r_top + PTR_ONE;
                w_count_nxt = CNT_ONE;
            end else begin
                w_waddr     = w_top_m1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_top   <= w_top_nxt;
            r_count <= w_count_nxt;
            // A new error on the clearing edge takes priority over the clear.
            r_ovf   <= w_ovf_set | (r_ovf & ~err_clr);
            r_unf   <= w_unf_set | (r_unf & ~err_clr);
        end
    end

    ra_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (ra_in),
        .i_raddr (w_top_m1),
        .o_rdata (w_rdata)
    );

    assign ra_out        = w_empty ? '0 : w_rdata;
    assign count         = r_count;
    assign empty         = w_empty;
    assign full          = w_full;
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;
endmodule

// File: tb/tb_ra_stack.sv
// Bench for ra_stack: queue-based reference model, expected-response scoreboard and a decoupled monitor.
module tb_ra_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = WIDTH + CW + 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] ra_in = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] ra_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow_err;
    logic             underflow_err;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0]    exp_q[$];
    logic [WIDTH-1:0] m_stk[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    ra_stack dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .pop           (pop),
        .ra_in         (ra_in),
        .ra_out        (ra_out),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain LIFO list of addresses plus two sticky bits.
    task automatic model_step(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
        logic ovf_set = 1'b0;
        logic unf_set = 1'b0;
        if (p && !q) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(d);
            else begin
                ovf_set = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
                void'(m_stk.pop_front());
                m_stk.push_back(d);
`endif
            end
        end else if (q && !p) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else unf_set = 1'b1;
        end else if (p && q) begin
            if (m_stk.size() > 0) m_stk[m_stk.size()-1] = d;
            else m_stk.push_back(d);
        end
        m_ovf = ovf_set | (m_ovf & ~c);
        m_unf = unf_set | (m_unf & ~c);
    endtask

    function automatic logic [EW-1:0] model_exp();
        logic [WIDTH-1:0] top_v;
        int n;
        n     = m_stk.size();
        top_v = (n > 0) ? m_stk[n-1] : '0;
        return {top_v, CW'(n), (n == 0), (n == DEPTH), m_ovf, m_unf};
    endfunction

    task automatic op(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
        @(negedge clk);
        push = p; pop = q; ra_in = d; err_clr = c;
        model_step(p, q, d, c);
        exp_q.push_back(model_exp());
    endtask

    task automatic async_reset_check();
        op(1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_ra_out", 32'(ra_out), 32'd0);
        chk("async_rst_flags", 32'({overflow_err, underflow_err}), 32'd0);
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every cycle with an outstanding expectation, compare just after the edge.
    always @(posedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {ra_out, count, empty, full, overflow_err, underflow_err};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL scoreboard t=%0t: got ra_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b expected ra_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                         $time, a[EW-1 -: WIDTH], a[CW+3:4], a[3], a[2], a[1], a[0],
                         e[EW-1 -: WIDTH], e[CW+3:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        int r;
        #2;
        chk("reset_ra_out", 32'(ra_out), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty_full", 32'({empty, full}), 32'b10);
        chk("reset_flags", 32'({overflow_err, underflow_err}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic push then pop to underflow.
        op(1, 0, 16'h0010, 0);
        op(1, 0, 16'h0020, 0);
        op(1, 0, 16'h0030, 0);
        for (int i = 0; i < 4; i++) op(0, 1, '0, 0);
        op(0, 0, '0, 0);

        // Fill, then push while full.
        async_reset_check();
        for (int i = 0; i < 8; i++) op(1, 0, 16'h0100 + 16'(i), 0);
        op(1, 0, 16'h0200, 0);
        for (int i = 0; i < 9; i++) op(0, 1, '0, 0);

        // Tail-call replace on a two-entry stack.
        async_reset_check();
        op(1, 0, 16'h0A00, 0);
        op(1, 0, 16'h0B00, 0);
        op(1, 1, 16'h0C00, 0);
        op(0, 1, '0, 0);
        op(0, 1, '0, 0);
        op(1, 1, 16'h0D00, 0);

        // Sticky flag set beats clear; clear alone drops it.
        async_reset_check();
        op(0, 1, '0, 0);
        op(0, 1, '0, 1);
        op(0, 0, '0, 1);
        op(0, 0, '0, 0);

        // Asynchronous reset with five entries.
        for (int i = 0; i < 5; i++) op(1, 0, 16'h0300 + 16'(i), 0);
        async_reset_check();

        // Randomised traffic, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      op(1, 0, 16'($urandom), ($urandom_range(0, 15) == 0));
            else if (r < 82) op(0, 1, '0, ($urandom_range(0, 15) == 0));
            else if (r < 92) op(1, 1, 16'($urandom), ($urandom_range(0, 15) == 0));
            else             op(0, 0, '0, ($urandom_range(0, 7) == 0));
            if (n % 150 == 149) async_reset_check();
        end
        op(0, 0, '0, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
